// File: rtl/array_host_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : array_host_pkg
//  Description : Shared types and widths for the array host sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package array_host_pkg;

    localparam int INSTR_W = 32;
    localparam int REG_AW  = 10;
    localparam int DATA_W  = 16;
    localparam int RBLEN_W = 11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ARM   = 3'd2,
        S_WAIT  = 3'd3,
        S_READ  = 3'd4,
        S_HOLD  = 3'd5
    } ahs_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [REG_AW-1:0]  rb_base;
        logic [RBLEN_W-1:0] rb_len;
    } ahs_entry_t;

endpackage
`default_nettype wire

// File: rtl/ahs_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ahs_cmd_fifo
//  Description : Synchronous command FIFO with registered occupancy count.
//                Head entry is presented on rd_data without a read strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahs_cmd_fifo
    import array_host_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  ahs_entry_t wr_data,
    output logic       full,
    input  logic       pop,
    output ahs_entry_t rd_data,
    output logic       empty
);

    localparam int C_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int C_CNT_W = $clog2(FIFO_DEPTH) + 1;

    ahs_entry_t         r_mem [FIFO_DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == C_CNT_W'(FIFO_DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rd_data   = r_mem[r_rd_ptr];

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/array_host_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : array_host_sequencer
//  Description : Host-side initiator: queues instructions, issues them to the
//                array controller, waits for completion and streams a
//                PE-major readback window to the host.
//  Revision    : 1.0 - initial release
// ============================================================================
module array_host_sequencer
    import array_host_pkg::*;
#(
    parameter int SIZE       = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int READ_LAT   = 1,
    parameter int TIMEOUT    = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] cmd_instr,
    input  logic [REG_AW-1:0]  cmd_rb_base,
    input  logic [RBLEN_W-1:0] cmd_rb_len,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic               start,
    input  logic               finish_flag,
    output logic [SIZE-1:0]    PE_Addr,
    output logic [REG_AW-1:0]  RegAddr,
    input  logic [DATA_W-1:0]  data,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               err_timeout
);

    localparam int             C_NUM_PE = SIZE * SIZE;
    localparam int             C_TO_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int             C_LAT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [SIZE-1:0] C_LAST_PE = SIZE'(C_NUM_PE - 1);

    ahs_state_e         r_state;
    ahs_state_e         w_state_next;

    ahs_entry_t         w_wr_entry;
    ahs_entry_t         w_rd_entry;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    logic [INSTR_W-1:0] r_instr;
    logic [REG_AW-1:0]  r_rb_base;
    logic [RBLEN_W-1:0] r_rb_len;
    logic [RBLEN_W-1:0] r_word_cnt;
    logic [C_TO_W-1:0]  r_tcnt;
    logic [C_LAT_W-1:0] r_lat;
    logic               r_fin_d;
    logic [SIZE-1:0]    r_pe;
    logic [REG_AW-1:0]  r_reg;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_err;

    logic               w_fin_edge;
    logic               w_timeout;
    logic               w_lat_done;
    logic               w_pe_done;
    logic               w_last_reg;

    assign w_wr_entry = '{instr: cmd_instr, rb_base: cmd_rb_base, rb_len: cmd_rb_len};
    assign w_push     = cmd_valid && !w_full;
    assign w_pop      = (r_state == S_IDLE) && !w_empty;

    ahs_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_push),
        .wr_data (w_wr_entry),
        .full    (w_full),
        .pop     (w_pop),
        .rd_data (w_rd_entry),
        .empty   (w_empty)
    );

    // Completion only on a fresh rising edge, so a flag left high by the
    // previous operation never completes the current one.
    assign w_fin_edge = finish_flag && !r_fin_d;
    assign w_timeout  = (r_tcnt == C_TO_W'(TIMEOUT - 1));
    assign w_lat_done = (r_lat == C_LAT_W'(READ_LAT - 1));
    assign w_pe_done  = (r_word_cnt == r_rb_len - RBLEN_W'(1));
    // 10-bit wrap: with rb_len=1024 the low bits are 0 and the last register
    // of the window is rb_base-1.
    assign w_last_reg = (r_reg == r_rb_base + r_rb_len[REG_AW-1:0] - REG_AW'(1));

    assign cmd_ready   = !w_full;
    assign start       = (r_state == S_ISSUE);
    assign instruction = r_instr;
    assign PE_Addr     = r_pe;
    assign RegAddr     = r_reg;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign busy        = (r_state != S_IDLE) || !w_empty;
    assign err_timeout = r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decision.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_ARM;
            S_ARM:   w_state_next = S_WAIT;
            S_WAIT: begin
                if (w_fin_edge) begin
                    w_state_next = (r_rb_len == '0) ? S_IDLE : S_READ;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_READ:  if (w_lat_done) w_state_next = S_HOLD;
            S_HOLD: begin
                if (out_ready) begin
                    w_state_next = r_out_last ? S_IDLE : S_READ;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Working registers, readback address walk and host output word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr     <= '0;
            r_rb_base   <= '0;
            r_rb_len    <= '0;
            r_word_cnt  <= '0;
            r_tcnt      <= '0;
            r_lat       <= '0;
            r_fin_d     <= 1'b0;
            r_pe        <= '0;
            r_reg       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_fin_d <= finish_flag;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_instr   <= w_rd_entry.instr;
                        r_rb_base <= w_rd_entry.rb_base;
                        r_rb_len  <= w_rd_entry.rb_len;
                    end
                end
                S_ISSUE: r_tcnt <= '0;
                S_WAIT: begin
                    if (w_fin_edge) begin
                        r_pe       <= '0;
                        r_reg      <= r_rb_base;
                        r_lat      <= '0;
                        r_word_cnt <= '0;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + C_TO_W'(1);
                    end
                end
                S_READ: begin
                    if (w_lat_done) begin
                        r_out_data  <= data;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_pe == C_LAST_PE) && w_last_reg;
                    end else begin
                        r_lat <= r_lat + C_LAT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (!r_out_last) begin
                            r_lat <= '0;
                            if (w_pe_done) begin
                                r_word_cnt <= '0;
                                r_reg      <= r_rb_base;
                                r_pe       <= r_pe + SIZE'(1);
                            end else begin
                                r_word_cnt <= r_word_cnt + RBLEN_W'(1);
                                r_reg      <= r_reg + REG_AW'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
